// File: rtl/top_pkg.sv
// Shared definitions for the multicycle MIPS board design: FSM states,
// opcode/funct constants, ALU control, I/O map, the built-in program and
// the hex-to-segment table.
package top_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_ZERO
  } alu_op_e;

  // Byte addresses below MEM_LIMIT hit RAM; 0x80..0x8F is the I/O window.
  localparam logic [31:0] MEM_LIMIT = 32'h0000_0080;
  localparam logic [31:0] IO_BTN    = 32'h0000_0080;
  localparam logic [31:0] IO_SWA    = 32'h0000_0084;
  localparam logic [31:0] IO_SWB    = 32'h0000_0088;
  localparam logic [31:0] IO_DISP   = 32'h0000_008C;

  localparam int PROG_WORDS = 7;

  // Built-in program. The sw uses $8 as base: $8 is 1..3 whenever the
  // loop falls through, so the store lands on 0x8D..0x8F, which decodes
  // to the display register word.
  function automatic logic [31:0] prog_word(input int idx);
    case (idx)
      0:       prog_word = 32'h8C08_0080; // lw  $8, 0x80($0)
      1:       prog_word = 32'h1100_FFFE; // beq $8, $0, -2
      2:       prog_word = 32'h8C09_0084; // lw  $9, 0x84($0)
      3:       prog_word = 32'h8C0A_0088; // lw  $10,0x88($0)
      4:       prog_word = 32'h012A_5820; // add $11,$9,$10
      5:       prog_word = 32'hAD0B_008C; // sw  $11,0x8C($8)
      6:       prog_word = 32'h0800_0000; // j   0x00
      default: prog_word = 32'h0000_0000;
    endcase
  endfunction

  function automatic alu_op_e alu_ctl(input logic [5:0] funct);
    case (funct)
      FN_ADD:  alu_ctl = ALU_ADD;
      FN_SUB:  alu_ctl = ALU_SUB;
      FN_AND:  alu_ctl = ALU_AND;
      FN_OR:   alu_ctl = ALU_OR;
      FN_SLT:  alu_ctl = ALU_SLT;
      default: alu_ctl = ALU_ZERO;
    endcase
  endfunction

  function automatic logic [31:0] alu_calc(input alu_op_e op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      ALU_ADD: alu_calc = a + b;
      ALU_SUB: alu_calc = a - b;
      ALU_AND: alu_calc = a & b;
      ALU_OR:  alu_calc = a | b;
      ALU_SLT: alu_calc = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: alu_calc = 32'd0;
    endcase
  endfunction

  // Active-low segments {a,b,c,d,e,f,g}.
  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_seg = 7'b0000001;
      4'h1: hex_seg = 7'b1001111;
      4'h2: hex_seg = 7'b0010010;
      4'h3: hex_seg = 7'b0000110;
      4'h4: hex_seg = 7'b1001100;
      4'h5: hex_seg = 7'b0100100;
      4'h6: hex_seg = 7'b0100000;
      4'h7: hex_seg = 7'b0001111;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0000100;
      4'hA: hex_seg = 7'b0001000;
      4'hB: hex_seg = 7'b1100000;
      4'hC: hex_seg = 7'b0110001;
      4'hD: hex_seg = 7'b1000010;
      4'hE: hex_seg = 7'b0110000;
      default: hex_seg = 7'b0111000;
    endcase
  endfunction

endpackage

// File: rtl/top_if.sv
// Display bus between the core/I/O block and the scan multiplexer.
// The bus carries level signals only: no valid/ready, values are sampled
// continuously by the multiplexer and segment outputs follow combinationally.
interface top_if;
  logic [7:0]  sw_hi;
  logic [7:0]  sw_lo;
  logic [15:0] disp_lo;
  logic [7:0]  an;
  logic        dp;
  logic [6:0]  a2g;

  modport master (output sw_hi, sw_lo, disp_lo, input an, dp, a2g);
  modport slave  (input sw_hi, sw_lo, disp_lo, output an, dp, a2g);
endinterface

// File: rtl/top_hex7seg_mux.sv
// Eight-digit 7-segment scan multiplexer. A free-running counter selects
// one digit at a time. Build option SIM_FAST_SCAN_EN selects counter bits
// [2:0] (one digit per clock) instead of [SCAN_MSB:SCAN_MSB-2].
module hex7seg_mux
  import top_pkg::*;
#(
  parameter int SCAN_MSB = 19
) (
  input logic  clk,
  input logic  reset,
  top_if.slave bus
);

  logic [SCAN_MSB:0] scan_cnt;
  logic [2:0]        digit_sel;
  logic [3:0]        nibble;

  // Free-running scan counter.
  always_ff @(posedge clk) begin
    if (reset) scan_cnt <= '0;
    else       scan_cnt <= scan_cnt + {{SCAN_MSB{1'b0}}, 1'b1};
  end

`ifdef SIM_FAST_SCAN_EN
  assign digit_sel = scan_cnt[2:0];
`else
  assign digit_sel = scan_cnt[SCAN_MSB:SCAN_MSB-2];
`endif

  // Pick the nibble shown on the currently enabled digit.
  always_comb begin
    nibble = 4'h0;
    case (digit_sel)
      3'd7: nibble = bus.sw_hi[7:4];
      3'd6: nibble = bus.sw_hi[3:0];
      3'd5: nibble = bus.sw_lo[7:4];
      3'd4: nibble = bus.sw_lo[3:0];
      3'd3: nibble = bus.disp_lo[15:12];
      3'd2: nibble = bus.disp_lo[11:8];
      3'd1: nibble = bus.disp_lo[7:4];
      default: nibble = bus.disp_lo[3:0];
    endcase
  end

  assign bus.an  = ~(8'd1 << digit_sel);
  assign bus.dp  = 1'b1;
  assign bus.a2g = hex_seg(nibble);

endmodule

// File: rtl/top.sv
// Multicycle MIPS core with unified memory, memory-mapped buttons/switches
// and a display register shown on an 8-digit 7-segment display.
// Build option SIM_FAST_SCAN_EN (in hex7seg_mux) speeds the digit scan.
module top
  import top_pkg::*;
#(
  parameter int MEM_WORDS = 32,
  parameter int SCAN_MSB  = 19
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        BTNL,
  input  logic        BTNR,
  input  logic [15:0] SW,
  output logic [7:0]  AN,
  output logic        DP,
  output logic [6:0]  A2G
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  // FSM state doubles as the debug view of the core.
  state_e      state;
  logic [31:0] pc, ir, mdr, a_reg, b_reg, alu_out, disp_reg;
  logic [31:0] rf  [32];
  logic [31:0] mem [MEM_WORDS];

  logic [17:0] sync1, sync2;
  logic        btnl_s, btnr_s;
  logic [15:0] sw_s;
  assign {btnl_s, btnr_s, sw_s} = sync2;

  logic [5:0]    opcode, funct;
  logic [4:0]    rs, rt, rd;
  logic [31:0]   imm_sext, br_off, rf_a, rf_b;
  logic [31:0]   mem_addr, io_word, rd_data;
  logic [5:0]    word_sel;
  logic [AW-1:0] mem_idx;
  logic          unused_shamt;

  assign opcode       = ir[31:26];
  assign rs           = ir[25:21];
  assign rt           = ir[20:16];
  assign rd           = ir[15:11];
  assign funct        = ir[5:0];
  assign unused_shamt = ^ir[10:6];
  assign imm_sext     = {{16{ir[15]}}, ir[15:0]};
  assign br_off       = {imm_sext[29:0], 2'b00};
  assign rf_a         = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rf_b         = (rt == 5'd0) ? 32'd0 : rf[rt];

  // FETCH addresses with PC, every other memory access with ALUOut.
  assign mem_addr = (state == FETCH) ? pc : alu_out;
  assign io_word  = {mem_addr[31:2], 2'b00};
  assign word_sel = {1'b0, mem_addr[6:2]};
  assign mem_idx  = AW'(word_sel % 6'(MEM_WORDS));

  // Read decode: RAM below 0x80, I/O words at 0x80..0x8F, zero elsewhere.
  always_comb begin
    rd_data = 32'd0;
    if (mem_addr < MEM_LIMIT) begin
      rd_data = mem[mem_idx];
    end else begin
      case (io_word)
        IO_BTN:  rd_data = {30'd0, btnl_s, btnr_s};
        IO_SWA:  rd_data = {24'd0, sw_s[15:8]};
        IO_SWB:  rd_data = {24'd0, sw_s[7:0]};
        IO_DISP: rd_data = disp_reg;
        default: rd_data = 32'd0;
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous board inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {BTNL, BTNR, SW};
      sync2 <= sync1;
    end
  end

  // Core FSM with datapath registers, register file and memory writes.
  // Reset has priority, so an instruction in flight never commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= '0;
      ir       <= '0;
      mdr      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      alu_out  <= '0;
      disp_reg <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= prog_word(i);
    end else begin
      case (state)
        FETCH: begin
          ir    <= rd_data;
          pc    <= pc + 32'd4;
          state <= DECODE;
        end
        DECODE: begin
          a_reg   <= rf_a;
          b_reg   <= rf_b;
          alu_out <= alu_calc(ALU_ADD, pc, br_off);
          case (opcode)
            OP_LW, OP_SW: state <= MEMADR;
            OP_RTYPE:     state <= EXECUTE;
            OP_BEQ:       state <= BRANCH;
            OP_ADDI:      state <= ADDIEXEC;
            OP_J:         state <= JUMP;
            default:      state <= FETCH;
          endcase
        end
        MEMADR: begin
          alu_out <= alu_calc(ALU_ADD, a_reg, imm_sext);
          state   <= (opcode == OP_SW) ? MEMWR : MEMRD;
        end
        MEMRD: begin
          mdr   <= rd_data;
          state <= MEMWB;
        end
        MEMWB: begin
          if (rt != 5'd0) rf[rt] <= mdr;
          state <= FETCH;
        end
        MEMWR: begin
          if (mem_addr < MEM_LIMIT) mem[mem_idx] <= b_reg;
          else if (io_word == IO_DISP) disp_reg <= b_reg;
          state <= FETCH;
        end
        EXECUTE: begin
          alu_out <= alu_calc(alu_ctl(funct), a_reg, b_reg);
          state   <= ALUWB;
        end
        ALUWB: begin
          if (rd != 5'd0) rf[rd] <= alu_out;
          state <= FETCH;
        end
        BRANCH: begin
          if (a_reg == b_reg) pc <= alu_out;
          state <= FETCH;
        end
        ADDIEXEC: begin
          alu_out <= alu_calc(ALU_ADD, a_reg, imm_sext);
          state   <= ADDIWB;
        end
        ADDIWB: begin
          if (rt != 5'd0) rf[rt] <= alu_out;
          state <= FETCH;
        end
        JUMP: begin
          pc    <= {pc[31:28], ir[25:0], 2'b00};
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  top_if disp_bus ();

  assign disp_bus.sw_hi   = sw_s[15:8];
  assign disp_bus.sw_lo   = sw_s[7:0];
  assign disp_bus.disp_lo = disp_reg[15:0];
  assign AN  = disp_bus.an;
  assign DP  = disp_bus.dp;
  assign A2G = disp_bus.a2g;

  hex7seg_mux #(.SCAN_MSB(SCAN_MSB)) u_mux (
    .clk   (clk),
    .reset (reset),
    .bus   (disp_bus)
  );

endmodule

// File: tb/tb_top.sv
// Directed bench for top: reset state, idle polling loop, switch addition
// via the built-in program, digit scan/encoding and reset during a store.
module tb_top;
  import top_pkg::*;

  localparam int SCAN_MSB_TB = 4;
`ifdef SIM_FAST_SCAN_EN
  localparam int PER = 1;
`else
  localparam int PER = 4;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        btnl, btnr;
  logic [15:0] sw;
  logic [7:0]  an;
  logic        dp;
  logic [6:0]  a2g;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];
  logic [6:0] seg_by_digit [8];
  int         bad_scan;

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  top #(.MEM_WORDS(32), .SCAN_MSB(SCAN_MSB_TB)) dut (
    .clk   (clk),
    .reset (reset),
    .BTNL  (btnl),
    .BTNR  (btnr),
    .SW    (sw),
    .AN    (an),
    .DP    (dp),
    .A2G   (a2g)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Driver tasks.
  task automatic set_inputs(input logic l, input logic r, input logic [15:0] s);
    btnl = l;
    btnr = r;
    sw   = s;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_disp(input string tag, input logic [31:0] exp, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (dut.disp_reg === exp) hit = 1'b1;
    end
    check(tag, dut.disp_reg, exp);
  endtask

  task automatic wait_memwr(input string tag, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (dut.state == MEMWR) hit = 1'b1;
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  task automatic capture_digits();
    bad_scan = 0;
    for (int d = 0; d < 8; d++) seg_by_digit[d] = 7'h7F;
    for (int k = 0; k < 16 * PER; k++) begin
      @(negedge clk);
      if (!$onehot(~an) || dp !== 1'b1) bad_scan++;
      else for (int d = 0; d < 8; d++) if (an[d] == 1'b0) seg_by_digit[d] = a2g;
    end
  endtask

  // Scoreboard: expected segment codes are queued digit 0 first.
  task automatic check_digits(input string tag);
    logic [6:0] exp;
    check({tag, "_scan"}, 32'(bad_scan), 32'd0);
    for (int d = 0; d < 8; d++) begin
      exp = exp_q.pop_front();
      check($sformatf("%s_d%0d", tag, d), 32'(seg_by_digit[d]), 32'(exp));
    end
  endtask

  initial begin
    logic [7:0] one;
    logic [7:0] exp_an;
    int bad_pc;
    one   = 8'd1;
    reset = 1'b1;
    set_inputs(1'b0, 1'b0, 16'h0408);

    // Reset state and idle polling loop.
    apply_reset();
    check("rst_pc",    dut.pc, 32'd0);
    check("rst_state", 32'(dut.state), 32'(FETCH));
    check("rst_disp",  dut.disp_reg, 32'd0);
    check("rst_dp",    32'(dp), 32'd1);
    check("rst_a2g",   32'(a2g), 32'(7'b0000001));
    check("rst_mem0",  dut.mem[0], 32'h8C08_0080);
    check("rst_mem5",  dut.mem[5], 32'hAD0B_008C);
    check("rst_mem7",  dut.mem[7], 32'd0);
    bad_pc = 0;
    for (int k = 0; k < 200; k++) begin
      if (k < 64) begin
        exp_an = ~(one << ((k / PER) % 8));
        check("an_step", 32'(an), 32'(exp_an));
      end
      if (dut.state == FETCH && dut.pc != 32'h0 && dut.pc != 32'h4) bad_pc++;
      @(negedge clk);
    end
    check("idle_fetch_pc", 32'(bad_pc), 32'd0);
    check("idle_disp",     dut.disp_reg, 32'd0);
    check("idle_dp",       32'(dp), 32'd1);

    // Both buttons pressed: 0x04 + 0x08.
    apply_reset();
    set_inputs(1'b1, 1'b1, 16'h0408);
    wait_disp("sum_0c", 32'h0000_000C, 40);
    check("rf8",  dut.rf[8],  32'd3);
    check("rf9",  dut.rf[9],  32'h04);
    check("rf10", dut.rf[10], 32'h08);
    check("rf11", dut.rf[11], 32'h0C);
    exp_q.push_back(7'b0110001); // d0 C
    exp_q.push_back(7'b0000001); // d1 0
    exp_q.push_back(7'b0000001); // d2 0
    exp_q.push_back(7'b0000001); // d3 0
    exp_q.push_back(7'b0000000); // d4 8
    exp_q.push_back(7'b0000001); // d5 0
    exp_q.push_back(7'b1001100); // d6 4
    exp_q.push_back(7'b0000001); // d7 0
    capture_digits();
    check_digits("dig_0408");

    // New switches right after a store completes: 0xFF + 0x01.
    wait_memwr("memwr_seen", 60);
    @(negedge clk);
    set_inputs(1'b1, 1'b1, 16'hFF01);
    wait_disp("sum_100", 32'h0000_0100, 40);
    check("rf11_100", dut.rf[11], 32'h100);
    exp_q.push_back(7'b0000001); // d0 0
    exp_q.push_back(7'b0000001); // d1 0
    exp_q.push_back(7'b1001111); // d2 1
    exp_q.push_back(7'b0000001); // d3 0
    exp_q.push_back(7'b1001111); // d4 1
    exp_q.push_back(7'b0000001); // d5 0
    exp_q.push_back(7'b0111000); // d6 F
    exp_q.push_back(7'b0111000); // d7 F
    capture_digits();
    check_digits("dig_ff01");

    // Reset asserted while the store is in its MEMWR cycle.
    set_inputs(1'b1, 1'b1, 16'h0408);
    apply_reset();
    wait_memwr("memwr_abort", 60);
    reset = 1'b1;
    @(negedge clk);
    check("abort_disp",  dut.disp_reg, 32'd0);
    check("abort_pc",    dut.pc, 32'd0);
    check("abort_state", 32'(dut.state), 32'(FETCH));
    check("abort_mem5",  dut.mem[5], 32'hAD0B_008C);
    check("abort_rf11",  dut.rf[11], 32'd0);
    check("abort_an",    32'(an), 32'hFE);
    reset = 1'b0;
    @(negedge clk);

    // Final report.
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
